// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   - funct3 width/sign codes for loads and stores
//   - FSM state encoding
//   - byte-enable base patterns (shifted by the byte offset)
//   - f3_illegal(): flags funct3 codes that have no meaning for the direction
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    // Loads accept b/h/w/bu/hu; stores only accept b/h/w.
    function automatic logic f3_illegal(input logic is_load, input logic [2:0] f3);
        if (is_load) begin
            return !((f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                     (f3 == F3_BU) || (f3 == F3_HU));
        end
        return (f3 > F3_W);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane alignment for the load/store unit.
// Inputs : funct3 (width/sign), addr_lo (byte offset), rs2_data (store data,
//          right-justified), dmem_rdata (read word).
// Outputs: be (store byte enables), wdata (lane-replicated store data),
//          load_data (extracted and extended load value), misalign (offset
//          not a multiple of the access size).
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rs2_data,
    input  logic [31:0] dmem_rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misalign
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    always_comb begin
        be       = BE_WORD;
        wdata    = rs2_data;
        misalign = 1'b0;
        // funct3[1:0] encodes the size for both loads and stores.
        case (funct3[1:0])
            2'b00: begin
                be    = BE_BYTE << addr_lo;
                wdata = {4{rs2_data[7:0]}};
            end
            2'b01: begin
                be       = BE_HALF << addr_lo;
                wdata    = {2{rs2_data[15:0]}};
                misalign = addr_lo[0];
            end
            default: begin
                be       = BE_WORD;
                wdata    = rs2_data;
                misalign = (addr_lo != 2'b00);
            end
        endcase
    end

    always_comb begin
        rbyte = dmem_rdata[7:0];
        case (addr_lo)
            2'd0:    rbyte = dmem_rdata[7:0];
            2'd1:    rbyte = dmem_rdata[15:8];
            2'd2:    rbyte = dmem_rdata[23:16];
            default: rbyte = dmem_rdata[31:24];
        endcase
        rhalf = addr_lo[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

        case (funct3)
            F3_B:    load_data = {{24{rbyte[7]}}, rbyte};
            F3_BU:   load_data = {24'd0, rbyte};
            F3_H:    load_data = {{16{rhalf[15]}}, rhalf};
            F3_HU:   load_data = {16'd0, rhalf};
            default: load_data = dmem_rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: initiator side of the data-memory port.
// Core side : req_valid/req_ready handshake (accept when both high in IDLE),
//             mem_read/mem_write direction, funct3, alu_result address,
//             rs2_data store data; resp_valid pulse with load_data and fault.
// Memory    : dmem_req/we/addr/be/wdata held stable until dmem_gnt;
//             dmem_rvalid/dmem_rdata return load data in WAIT only.
// Debug     : state_dbg exposes the current FSM state.
// Handshakes: the core may present req_valid at any time; it is taken only
//             when req_ready=1. dmem_req stays high with stable fields until
//             the cycle dmem_gnt=1. dmem_rvalid counts only in WAIT.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [2:0]            funct3,
    input  logic [ADDR_WIDTH-1:0] alu_result,
    input  logic [DATA_WIDTH-1:0] rs2_data,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic                  fault,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [3:0]            dmem_be,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    input  logic                  dmem_gnt,
    input  logic                  dmem_rvalid,
    input  logic [DATA_WIDTH-1:0] dmem_rdata,
    output lsu_state_e            state_dbg
);

    lsu_state_e            state_q, state_d;
    logic [2:0]            f3_q, f3_d;
    logic [1:0]            addr_lo_q, addr_lo_d;
    logic                  is_load_q, is_load_d;
    logic                  req_ready_q, req_ready_d;
    logic                  resp_valid_q, resp_valid_d;
    logic                  fault_q, fault_d;
    logic [DATA_WIDTH-1:0] load_data_q, load_data_d;
    logic                  dmem_req_q, dmem_req_d;
    logic                  dmem_we_q, dmem_we_d;
    logic [ADDR_WIDTH-1:0] dmem_addr_q, dmem_addr_d;
    logic [3:0]            dmem_be_q, dmem_be_d;
    logic [DATA_WIDTH-1:0] dmem_wdata_q, dmem_wdata_d;

    logic [2:0]            al_f3;
    logic [1:0]            al_addr;
    logic [3:0]            al_be;
    logic [DATA_WIDTH-1:0] al_wdata;
    logic [DATA_WIDTH-1:0] al_load;
    logic                  al_misalign;
    logic                  req_fault;

    // In IDLE the aligner looks at the incoming request (to build be/wdata and
    // the misalign check); afterwards it uses the latched fields for extraction.
    assign al_f3   = (state_q == ST_IDLE) ? funct3 : f3_q;
    assign al_addr = (state_q == ST_IDLE) ? alu_result[1:0] : addr_lo_q;

    lsu_align u_align (
        .funct3     (al_f3),
        .addr_lo    (al_addr),
        .rs2_data   (rs2_data),
        .dmem_rdata (dmem_rdata),
        .be         (al_be),
        .wdata      (al_wdata),
        .load_data  (al_load),
        .misalign   (al_misalign)
    );

    assign req_fault = (mem_read == mem_write) || f3_illegal(mem_read, funct3) || al_misalign;

    always_comb begin
        state_d      = state_q;
        f3_d         = f3_q;
        addr_lo_d    = addr_lo_q;
        is_load_d    = is_load_q;
        fault_d      = fault_q;
        load_data_d  = load_data_q;
        dmem_req_d   = dmem_req_q;
        dmem_we_d    = dmem_we_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_be_d    = dmem_be_q;
        dmem_wdata_d = dmem_wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    f3_d        = funct3;
                    addr_lo_d   = alu_result[1:0];
                    is_load_d   = mem_read;
                    load_data_d = '0;
                    if (req_fault) begin
                        // Rejected accesses never reach memory.
                        fault_d = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        dmem_req_d   = 1'b1;
                        dmem_we_d    = mem_write;
                        dmem_addr_d  = {alu_result[ADDR_WIDTH-1:2], 2'b00};
                        dmem_be_d    = mem_read ? BE_WORD : al_be;
                        dmem_wdata_d = mem_read ? '0 : al_wdata;
                        state_d      = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                // An rvalid coinciding with gnt is not taken here.
                if (dmem_gnt) begin
                    dmem_req_d = 1'b0;
                    state_d    = is_load_q ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                if (dmem_rvalid) begin
                    load_data_d = al_load;
                    state_d     = ST_RESP;
                end
            end
            default: begin
                fault_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        req_ready_d  = (state_d == ST_IDLE);
        resp_valid_d = (state_d == ST_RESP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            f3_q         <= '0;
            addr_lo_q    <= '0;
            is_load_q    <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            fault_q      <= 1'b0;
            load_data_q  <= '0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_be_q    <= '0;
            dmem_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            f3_q         <= f3_d;
            addr_lo_q    <= addr_lo_d;
            is_load_q    <= is_load_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            fault_q      <= fault_d;
            load_data_q  <= load_data_d;
            dmem_req_q   <= dmem_req_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_be_q    <= dmem_be_d;
            dmem_wdata_q <= dmem_wdata_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign fault      = fault_q;
    assign load_data  = load_data_q;
    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_be    = dmem_be_q;
    assign dmem_wdata = dmem_wdata_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed accesses from the test
// plan, a reset-in-WAIT scenario, then randomized accesses, all compared
// against a byte/size arithmetic reference model.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] alu_result;
    logic [31:0] rs2_data;
    logic        resp_valid;
    logic [31:0] load_data;
    logic        fault;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    lsu_state_e  state_dbg;

    int cmp_cnt  = 0;
    int fail_cnt = 0;
    logic [32:0] exp_q[$];  // {fault, load_data} per accepted access

    load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .funct3      (funct3),
        .alu_result  (alu_result),
        .rs2_data    (rs2_data),
        .resp_valid  (resp_valid),
        .load_data   (load_data),
        .fault       (fault),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_be     (dmem_be),
        .dmem_wdata  (dmem_wdata),
        .dmem_gnt    (dmem_gnt),
        .dmem_rvalid (dmem_rvalid),
        .dmem_rdata  (dmem_rdata),
        .state_dbg   (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard compare ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic void ref_model(input logic rd, input logic wr, input logic [2:0] f3,
                                      input logic [31:0] addr, input logic [31:0] rs2,
                                      input logic [31:0] rdata, output logic flt,
                                      output logic [3:0] be, output logic [31:0] wd,
                                      output logic [31:0] ld);
        int off;
        int size;
        logic [31:0] mask;
        logic [31:0] val;
        off  = int'(addr % 4);
        size = (f3 % 4 == 0) ? 1 : ((f3 % 4 == 1) ? 2 : 4);
        flt  = (rd == wr);
        if (rd && !wr) flt = flt || !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (wr && !rd) flt = flt || (f3 > 3'd2);
        flt = flt || ((off % size) != 0);
        be  = rd ? 4'hF : 4'(((1 << size) - 1) << off);
        wd  = '0;
        for (int i = 0; i < 4; i++) wd[8*i +: 8] = rs2[8*(i % size) +: 8];
        mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
        val  = (rdata >> (8 * off)) & mask;
        if (f3 < 3'd4 && size < 4 && val[8*size-1]) val = val | ~mask;
        ld = (flt || !rd) ? 32'd0 : val;
    endfunction

    // ---------------- driver: one access, open-loop memory schedule ----------------
    task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] rs2,
                             input logic [31:0] rdata, input int gd, input int rdl,
                             input bit hold, input string name);
        logic        flt;
        logic [3:0]  ebe;
        logic [31:0] ewd;
        logic [31:0] eld;
        logic [32:0] ent;
        int gnt_k;
        int rv_k;
        int resp_k;
        bit in_req;
        ref_model(rd, wr, f3, addr, rs2, rdata, flt, ebe, ewd, eld);
        exp_q.push_back({flt, eld});
        gnt_k  = 1 + gd;
        rv_k   = (!flt && rd) ? gnt_k + 1 + rdl : -1;
        resp_k = flt ? 1 : (rd ? rv_k + 1 : gnt_k + 1);

        @(posedge clk); #1;
        req_valid = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3;
        alu_result = addr; rs2_data = rs2;
        @(negedge clk);
        check({name, ".ready_idle"}, 32'(req_ready), 32'd1);

        for (int k = 1; k <= resp_k; k++) begin
            @(posedge clk); #1;
            req_valid = hold;
            if (hold) begin
                alu_result = $urandom;
                rs2_data   = $urandom;
                funct3     = 3'($urandom_range(0, 7));
            end
            in_req      = !flt && (k <= gnt_k);
            dmem_gnt    = !flt && (k == gnt_k);
            dmem_rvalid = 1'b0;
            dmem_rdata  = $urandom;
            if (!flt && rd && k == rv_k) begin
                dmem_rvalid = 1'b1;
                dmem_rdata  = rdata;
            end else if (in_req) begin
                dmem_rvalid = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            check({name, ".ready_busy"}, 32'(req_ready), 32'd0);
            check({name, ".dmem_req"}, 32'(dmem_req), 32'(in_req));
            if (in_req) begin
                check({name, ".addr"}, dmem_addr, addr & 32'hFFFF_FFFC);
                check({name, ".be"}, 32'(dmem_be), 32'(ebe));
                check({name, ".we"}, 32'(dmem_we), 32'(wr));
                if (wr) check({name, ".wdata"}, dmem_wdata, ewd);
            end
            check({name, ".resp_valid"}, 32'(resp_valid), 32'(k == resp_k));
            if (k == resp_k) begin
                ent = exp_q.pop_front();
                check({name, ".fault"}, 32'(fault), 32'(ent[32]));
                check({name, ".load_data"}, load_data, ent[31:0]);
            end
        end

        @(posedge clk); #1;
        req_valid = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0;
        @(negedge clk);
        check({name, ".resp_done"}, 32'(resp_valid), 32'd0);
        check({name, ".ready_back"}, 32'(req_ready), 32'd1);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        rst = 1'b1; req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        funct3 = 3'd0; alu_result = '0; rs2_data = '0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst.ready", 32'(req_ready), 32'd1);
        check("rst.resp_valid", 32'(resp_valid), 32'd0);
        check("rst.fault", 32'(fault), 32'd0);
        check("rst.load_data", load_data, 32'd0);
        check("rst.dmem_req", 32'(dmem_req), 32'd0);
        check("rst.dmem_we", 32'(dmem_we), 32'd0);
        check("rst.dmem_addr", dmem_addr, 32'd0);
        check("rst.dmem_be", 32'(dmem_be), 32'd0);
        check("rst.dmem_wdata", dmem_wdata, 32'd0);
        check("rst.state", 32'(state_dbg), 32'(ST_IDLE));

        do_access(1'b0, 1'b1, F3_B,  32'h1, 32'hA5,       32'h0,        0, 0, 1'b0, "sb");
        do_access(1'b1, 1'b0, F3_B,  32'h1, 32'h0,        32'h0000A500, 0, 0, 1'b0, "lb");
        do_access(1'b1, 1'b0, F3_BU, 32'h1, 32'h0,        32'h0000A500, 0, 0, 1'b0, "lbu");
        do_access(1'b0, 1'b1, F3_H,  32'h6, 32'hABCD,     32'h0,        0, 0, 1'b0, "sh");
        do_access(1'b1, 1'b0, F3_H,  32'h2, 32'h0,        32'hABCD0000, 0, 0, 1'b0, "lh");
        do_access(1'b1, 1'b0, F3_HU, 32'h2, 32'h0,        32'hABCD0000, 0, 0, 1'b0, "lhu");
        do_access(1'b0, 1'b1, F3_W,  32'h8, 32'h12345678, 32'h0,        3, 0, 1'b1, "sw_stall");
        do_access(1'b1, 1'b0, F3_W,  32'h8, 32'h0,        32'h12345678, 0, 2, 1'b1, "lw_stall");
        do_access(1'b0, 1'b1, F3_W,  32'hA, 32'h1,        32'h0,        0, 0, 1'b0, "flt_sw");
        do_access(1'b1, 1'b0, F3_H,  32'h3, 32'h0,        32'h0,        0, 0, 1'b0, "flt_lh");
        do_access(1'b1, 1'b0, 3'b011, 32'h0, 32'h0,       32'h0,        0, 0, 1'b0, "flt_f3");
        do_access(1'b1, 1'b1, F3_W,  32'h0, 32'h0,        32'h0,        0, 0, 1'b0, "flt_rw");

        // Reset while waiting for read data; the late rvalid must be dropped.
        @(posedge clk); #1;
        req_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = F3_W;
        alu_result = 32'h10;
        @(posedge clk); #1;
        req_valid = 1'b0; dmem_gnt = 1'b1;
        @(posedge clk); #1;
        dmem_gnt = 1'b0; rst = 1'b1;
        @(negedge clk);
        check("rstw.in_wait", 32'(state_dbg), 32'(ST_WAIT));
        @(posedge clk); #1;
        rst = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        check("rstw.dmem_req", 32'(dmem_req), 32'd0);
        check("rstw.state", 32'(state_dbg), 32'(ST_IDLE));
        check("rstw.ready", 32'(req_ready), 32'd1);
        check("rstw.resp0", 32'(resp_valid), 32'd0);
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        @(negedge clk);
        check("rstw.resp1", 32'(resp_valid), 32'd0);
        check("rstw.state1", 32'(state_dbg), 32'(ST_IDLE));
        do_access(1'b1, 1'b0, F3_W, 32'h0, 32'h0, 32'hCAFEF00D, 0, 0, 1'b0, "lw_after_rst");

        // Randomized accesses.
        for (int n = 0; n < 120; n++) begin
            int   r;
            logic rd;
            logic wr;
            r = $urandom_range(0, 9);
            if (r == 0) begin rd = 1'b1; wr = 1'b1; end
            else if (r == 1) begin rd = 1'b0; wr = 1'b0; end
            else begin rd = 1'(r % 2); wr = !rd; end
            do_access(rd, wr, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                      $urandom_range(0, 3), $urandom_range(0, 3),
                      1'($urandom_range(0, 1)), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule
